tbec_scrub_ctrl: RTL

Sequencing controller for a TBEC-RSC protected memory. It shares one single-port memory between host read requests and a periodic background scrubber. Every fetched 32-bit codeword goes through the external combinational TBEC-RSC decoder, and any codeword the decoder flags as corrected is re-encoded and written back. It sits between the host-side read interface and the memory/decoder/encoder datapath.

---
 rtl/tbec_scrub_ctrl_if.sv | 39 +++
 rtl/tbec_scrub_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/tbec_scrub_ctrl_if.sv
// ---------------------------------------------------------------------------
// tbec_scrub_ctrl_if
// Host read-request interface of the TBEC-RSC scrub controller.
//   host_req   : read request, held by the host until granted
//   host_addr  : read address, sampled by the controller in the grant cycle
//   host_gnt   : one-cycle pulse when the request is accepted
//   host_valid : one-cycle pulse when host_data/host_flag are valid
//   host_data  : corrected 16-bit data word
//   host_flag  : decoder flag belonging to host_data
// Modports: master = host side, slave = controller side.
// ---------------------------------------------------------------------------
interface tbec_scrub_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              host_req;
    logic [ADDR_W-1:0] host_addr;
    logic              host_gnt;
    logic              host_valid;
    logic [15:0]       host_data;
    logic [2:0]        host_flag;

    modport master (
        output host_req,
        output host_addr,
        input  host_gnt,
        input  host_valid,
        input  host_data,
        input  host_flag
    );

    modport slave (
        input  host_req,
        input  host_addr,
        output host_gnt,
        output host_valid,
        output host_data,
        output host_flag
    );
endinterface

// File: rtl/tbec_scrub_ctrl.sv
// ---------------------------------------------------------------------------
// tbec_scrub_ctrl
// Shares one single-port memory between host reads and a periodic background
// scrubber. Each fetched codeword is passed through the external TBEC-RSC
// decoder; corrected codewords are re-encoded and written back when the
// write-back path is compiled in.
//
// Build option: define TBEC_SCRUB_WB_EN to include the write-back (WB) state.
// Without it RESP always returns to IDLE and mem_we/enc_in/mem_wdata are 0.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   host (slave)        : host read request/grant/response interface
//   scrub_en            : enables the scrub timer
//   scrub_wrap          : pulse when the scrub pointer wraps to 0
//   corr_cnt            : saturating count of flagged codewords
//   busy                : high whenever the controller is not idle
//   mem_en/we/addr/wdata, mem_rdata : single-port memory (1-cycle read)
//   dec_in, dec_out, dec_flag       : combinational decoder
//   enc_in, enc_out                 : combinational encoder
// ---------------------------------------------------------------------------
module tbec_scrub_ctrl #(
    parameter int ADDR_W       = 8,
    parameter int SCRUB_PERIOD = 1024
) (
    input  logic                clk,
    input  logic                rst,
    tbec_scrub_ctrl_if.slave    host,
    input  logic                scrub_en,
    output logic                scrub_wrap,
    output logic [15:0]         corr_cnt,
    output logic                busy,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [31:0]         mem_wdata,
    input  logic [31:0]         mem_rdata,
    output logic [31:0]         dec_in,
    input  logic [15:0]         dec_out,
    input  logic [2:0]          dec_flag,
    output logic [15:0]         enc_in,
    input  logic [31:0]         enc_out
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_CAP  = 3'd2;
    localparam logic [2:0] S_CHK  = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;
`ifdef TBEC_SCRUB_WB_EN
    localparam logic [2:0] S_WB   = 3'd5;
`endif

    localparam logic [15:0] TIMER_LAST = 16'(SCRUB_PERIOD - 1);

    logic [2:0]        state_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              op_host_reg;    // current operation belongs to the host
    logic              last_host_reg;  // previous grant went to the host
    logic [31:0]       cw_reg;
    logic [15:0]       data_reg;
    logic [2:0]        flag_reg;
    logic [15:0]       corr_reg;
    logic [ADDR_W-1:0] ptr_reg;
    logic [15:0]       timer_reg;
    logic              pend_reg;

    logic grant_host;
    logic grant_scrub;
    logic timer_expire;
    logic idle;

    assign idle         = (state_reg == S_IDLE);
    assign timer_expire = scrub_en && (timer_reg == TIMER_LAST);

    // Alternating fairness: on contention the host wins unless it won last.
    assign grant_host  = idle && host.host_req && (!pend_reg || !last_host_reg);
    assign grant_scrub = idle && pend_reg && (!host.host_req || last_host_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            addr_reg      <= '0;
            op_host_reg   <= 1'b0;
            last_host_reg <= 1'b0;
            cw_reg        <= '0;
            data_reg      <= '0;
            flag_reg      <= '0;
            corr_reg      <= '0;
            ptr_reg       <= '0;
            timer_reg     <= '0;
            pend_reg      <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (grant_host) begin
                        state_reg     <= S_RD;
                        addr_reg      <= host.host_addr;
                        op_host_reg   <= 1'b1;
                        last_host_reg <= 1'b1;
                    end else if (grant_scrub) begin
                        state_reg     <= S_RD;
                        addr_reg      <= ptr_reg;
                        op_host_reg   <= 1'b0;
                        last_host_reg <= 1'b0;
                    end
                end
                S_RD:  state_reg <= S_CAP;
                S_CAP: begin
                    cw_reg    <= mem_rdata;
                    state_reg <= S_CHK;
                end
                S_CHK: begin
                    data_reg  <= dec_out;
                    flag_reg  <= dec_flag;
                    if ((dec_flag != 3'b000) && (corr_reg != 16'hFFFF)) begin
                        corr_reg <= corr_reg + 16'd1;
                    end
                    state_reg <= S_RESP;
                end
                S_RESP: begin
                    if (!op_host_reg) begin
                        ptr_reg <= ptr_reg + 1'b1;
                    end
`ifdef TBEC_SCRUB_WB_EN
                    state_reg <= (flag_reg != 3'b000) ? S_WB : S_IDLE;
`else
                    state_reg <= S_IDLE;
`endif
                end
                default: state_reg <= S_IDLE;
            endcase

            // Timer and pending flag; an expiry while a request is pending
            // (including the cycle that request is granted) is dropped.
            if (!scrub_en) begin
                timer_reg <= '0;
                pend_reg  <= 1'b0;
            end else begin
                timer_reg <= timer_expire ? 16'd0 : timer_reg + 16'd1;
                if (grant_scrub) begin
                    pend_reg <= 1'b0;
                end else if (timer_expire) begin
                    pend_reg <= 1'b1;
                end
            end
        end
    end

    // All outputs are forced to 0 while rst is high, so a reset landing in
    // RD or WB never issues a memory access.
    always_comb begin
        host.host_gnt   = 1'b0;
        host.host_valid = 1'b0;
        host.host_data  = '0;
        host.host_flag  = '0;
        scrub_wrap      = 1'b0;
        corr_cnt        = '0;
        busy            = 1'b0;
        mem_en          = 1'b0;
        mem_we          = 1'b0;
        mem_addr        = '0;
        mem_wdata       = '0;
        dec_in          = '0;
        enc_in          = '0;
        if (!rst) begin
            host.host_gnt = grant_host;
            corr_cnt      = corr_reg;
            busy          = !idle;
            case (state_reg)
                S_RD: begin
                    mem_en   = 1'b1;
                    mem_addr = addr_reg;
                end
                S_CHK: dec_in = cw_reg;
                S_RESP: begin
                    if (op_host_reg) begin
                        host.host_valid = 1'b1;
                        host.host_data  = data_reg;
                        host.host_flag  = flag_reg;
                    end else begin
                        scrub_wrap = (ptr_reg == {ADDR_W{1'b1}});
                    end
                end
`ifdef TBEC_SCRUB_WB_EN
                S_WB: begin
                    enc_in    = data_reg;
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = addr_reg;
                    mem_wdata = enc_out;
                end
`endif
                default: ;
            endcase
        end
    end

`ifndef TBEC_SCRUB_WB_EN
    // Encoder output has no consumer when write-back is not built.
    logic unused_enc_out;
    assign unused_enc_out = ^enc_out;
`endif

endmodule
